// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl -- main control FSM of the multi-cycle RV64I core.
//
// Sequences FETCH -> DECODE -> EXEC -> [MEM] -> [WB] over a single shared
// memory port with a req/ready handshake, and traps into a sticky FAULT
// state on an illegal opcode or a memory wait timeout.
//
// Parameters:
//   MEM_TIMEOUT  max cycles waiting for mem_ready in FETCH/MEM (0 = never)
//   TO_W         width of the wait counter, must hold MEM_TIMEOUT
//
// Optional build macro:
//   RETIRE_CNT_EN  when defined, retire_cnt counts pc_we pulses; otherwise
//                  retire_cnt is tied to zero and no counter is built.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   opcode              IR[6:0], valid from DECODE onward
//   branch_taken        ALU compare result, valid in EXEC
//   mem_ready           memory accepts/returns this cycle
//   mem_req, mem_we     memory request / write (store)
//   addr_sel            memory address: 0 = PC, 1 = ALU result
//   ir_we, pc_we        instruction register / PC write strobes
//   pc_src              0 = PC+4, 1 = branch target
//   alu_src_imm, alu_op ALU operand B select and operation class
//   reg_we, mem_to_reg  register-file write and writeback source
//   fault               sticky illegal-opcode/timeout indicator
//   retire_cnt          retired-instruction count
module multicycle_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int TO_W        = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [6:0]  opcode,
    input  logic        branch_taken,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        addr_sel,
    output logic        ir_we,
    output logic        pc_we,
    output logic        pc_src,
    output logic        alu_src_imm,
    output logic [1:0]  alu_op,
    output logic        reg_we,
    output logic        mem_to_reg,
    output logic        fault,
    output logic [31:0] retire_cnt
);

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_FAULT  = 3'd5
    } state_t;

    state_t          state_q, state_d;
    logic [TO_W-1:0] wait_q, wait_d;
    logic            timeout_hit;

    logic is_load, is_opimm, is_store, is_branch, is_op, is_legal;

    // Unqualified strobes; reset gating is applied at the output ports.
    logic       mem_req_c, mem_we_c, addr_sel_c, ir_we_c, pc_we_c, pc_src_c;
    logic       alu_src_imm_c, reg_we_c, mem_to_reg_c, fault_c;
    logic [1:0] alu_op_c;

    always_comb begin
        is_load   = (opcode == OPC_LOAD);
        is_opimm  = (opcode == OPC_OPIMM);
        is_store  = (opcode == OPC_STORE);
        is_branch = (opcode == OPC_BRANCH);
        is_op     = (opcode == OPC_OP);
        is_legal  = is_load | is_opimm | is_store | is_branch | is_op;
    end

    // Timeout fires on the last permitted wait cycle; a ready arriving in
    // that same cycle is checked first in the FSM and therefore wins.
    generate
        if (MEM_TIMEOUT > 0) begin : g_timeout
            assign timeout_hit = (wait_q == TO_W'(MEM_TIMEOUT - 1));
        end else begin : g_no_timeout
            assign timeout_hit = 1'b0;
        end
    endgenerate

    always_comb begin
        state_d       = state_q;
        mem_req_c     = 1'b0;
        mem_we_c      = 1'b0;
        addr_sel_c    = 1'b0;
        ir_we_c       = 1'b0;
        pc_we_c       = 1'b0;
        pc_src_c      = 1'b0;
        alu_src_imm_c = 1'b0;
        alu_op_c      = ALU_ADD;
        reg_we_c      = 1'b0;
        mem_to_reg_c  = 1'b0;
        fault_c       = 1'b0;

        case (state_q)
            S_FETCH: begin
                mem_req_c = 1'b1;
                ir_we_c   = mem_ready;
                if (mem_ready)        state_d = S_DECODE;
                else if (timeout_hit) state_d = S_FAULT;
            end
            S_DECODE: begin
                state_d = is_legal ? S_EXEC : S_FAULT;
            end
            S_EXEC: begin
                alu_src_imm_c = is_load | is_opimm | is_store;
                if (is_load | is_store) alu_op_c = ALU_ADD;
                else if (is_branch)     alu_op_c = ALU_SUB;
                else                    alu_op_c = ALU_FUNCT;

                if (is_branch) begin
                    pc_we_c  = 1'b1;
                    pc_src_c = branch_taken;
                    state_d  = S_FETCH;
                end else if (is_load | is_store) begin
                    state_d = S_MEM;
                end else if (is_op | is_opimm) begin
                    state_d = S_WB;
                end else begin
                    // IR is stable after DECODE, so this only guards
                    // against a corrupted instruction register.
                    state_d = S_FAULT;
                end
            end
            S_MEM: begin
                mem_req_c     = 1'b1;
                addr_sel_c    = 1'b1;
                mem_we_c      = is_store;
                alu_src_imm_c = 1'b1;
                alu_op_c      = ALU_ADD;
                if (mem_ready) begin
                    if (is_store) begin
                        pc_we_c = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (timeout_hit) begin
                    state_d = S_FAULT;
                end
            end
            S_WB: begin
                reg_we_c     = 1'b1;
                mem_to_reg_c = is_load;
                pc_we_c      = 1'b1;
                state_d      = S_FETCH;
            end
            S_FAULT: begin
                fault_c = 1'b1;
            end
            default: begin
                state_d = S_FAULT;
            end
        endcase
    end

    // Wait counter: counts stalled memory cycles, restarts on every
    // state change.
    always_comb begin
        if (state_d != state_q) begin
            wait_d = '0;
        end else if (((state_q == S_FETCH) || (state_q == S_MEM)) && !mem_ready) begin
            wait_d = wait_q + 1'b1;
        end else begin
            wait_d = wait_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    // All outputs, including the combinational strobes, read zero while
    // reset is held.
    assign mem_req     = mem_req_c     & ~reset;
    assign mem_we      = mem_we_c      & ~reset;
    assign addr_sel    = addr_sel_c    & ~reset;
    assign ir_we       = ir_we_c       & ~reset;
    assign pc_we       = pc_we_c       & ~reset;
    assign pc_src      = pc_src_c      & ~reset;
    assign alu_src_imm = alu_src_imm_c & ~reset;
    assign alu_op      = reset ? 2'b00 : alu_op_c;
    assign reg_we      = reg_we_c      & ~reset;
    assign mem_to_reg  = mem_to_reg_c  & ~reset;
    assign fault       = fault_c       & ~reset;

`ifdef RETIRE_CNT_EN
    // Counts pc_we pulses; FAULT never pulses pc_we, so the count freezes
    // there. Wraps naturally at 2^32.
    logic [31:0] retire_q, retire_d;

    always_comb begin
        retire_d = pc_we_c ? (retire_q + 32'd1) : retire_q;
    end

    always_ff @(posedge clk) begin
        if (reset) retire_q <= '0;
        else       retire_q <= retire_d;
    end

    assign retire_cnt = reset ? 32'd0 : retire_q;
`else
    assign retire_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
module tb_multicycle_ctrl;

    localparam logic [6:0] OPC_LOAD    = 7'b0000011;
    localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
    localparam logic [6:0] OPC_STORE   = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
    localparam logic [6:0] OPC_OP      = 7'b0110011;
    localparam logic [6:0] OPC_ILLEGAL = 7'b1111111;

    logic        clk = 1'b0;
    logic        reset;
    logic [6:0]  opcode;
    logic        branch_taken;
    logic        mem_ready;
    logic        mem_req, mem_we, addr_sel, ir_we, pc_we, pc_src;
    logic        alu_src_imm, reg_we, mem_to_reg, fault;
    logic [1:0]  alu_op;
    logic [31:0] retire_cnt;

    int checks = 0;
    int errors = 0;

    // Scoreboard: one entry per instruction expected to retire.
    typedef struct {
        int         lat;
        logic       pc_src;
        logic       reg_we;
        logic       mem_to_reg;
        logic [6:0] op;
    } exp_t;

    exp_t sb[$];
    int   lat_cnt = 0;

    multicycle_ctrl #(.MEM_TIMEOUT(16), .TO_W(5)) dut (
        .clk          (clk),
        .reset        (reset),
        .opcode       (opcode),
        .branch_taken (branch_taken),
        .mem_ready    (mem_ready),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .addr_sel     (addr_sel),
        .ir_we        (ir_we),
        .pc_we        (pc_we),
        .pc_src       (pc_src),
        .alu_src_imm  (alu_src_imm),
        .alu_op       (alu_op),
        .reg_we       (reg_we),
        .mem_to_reg   (mem_to_reg),
        .fault        (fault),
        .retire_cnt   (retire_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1, "watchdog expired");
    end

    // Retire monitor: every pc_we pulse pops one expected instruction and
    // compares latency (cycles since reset or previous retire) and strobes.
    always @(negedge clk) begin
        exp_t e;
        if (reset === 1'b1) begin
            lat_cnt = 0;
        end else begin
            lat_cnt = lat_cnt + 1;
            if (pc_we === 1'b1) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_retire: pc_we=1 at %0t, required no retire", $time);
                end else begin
                    e = sb.pop_front();
                    if (lat_cnt !== e.lat || pc_src !== e.pc_src ||
                        reg_we !== e.reg_we || mem_to_reg !== e.mem_to_reg) begin
                        errors++;
                        $display("FAIL retire op=%b: got lat=%0d pc_src=%b reg_we=%b mem_to_reg=%b, required lat=%0d pc_src=%b reg_we=%b mem_to_reg=%b",
                                 e.op, lat_cnt, pc_src, reg_we, mem_to_reg,
                                 e.lat, e.pc_src, e.reg_we, e.mem_to_reg);
                    end else begin
                        $display("retire op=%b lat=%0d pc_src=%b ok", e.op, lat_cnt, pc_src);
                    end
                end
                lat_cnt = 0;
            end
        end
    end

    // Holds reset for two edges and leaves the bench 1 ns after the edge
    // that starts the first FETCH cycle.
    task automatic apply_reset();
        reset        = 1'b1;
        mem_ready    = 1'b0;
        branch_taken = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Runs one instruction with fw stalled fetch cycles and mw stalled
    // memory cycles, checking strobes every cycle.
    task automatic run_instr(input logic [6:0] op, input logic taken,
                             input int fw, input int mw);
        logic ld, st, br, has_mem, has_wb, rdy;
        logic [6:0] obs, expv;
        logic       exp_imm;
        logic [1:0] exp_aop;
        int         total, ph;
        exp_t       e;
        ld      = (op == OPC_LOAD);
        st      = (op == OPC_STORE);
        br      = (op == OPC_BRANCH);
        has_mem = ld | st;
        has_wb  = !(st | br);
        total   = fw + 3 + (has_mem ? mw + 1 : 0) + (has_wb ? 1 : 0);

        e.lat        = total;
        e.pc_src     = br ? taken : 1'b0;
        e.reg_we     = has_wb;
        e.mem_to_reg = ld;
        e.op         = op;
        sb.push_back(e);

        opcode       = op;
        branch_taken = taken;
        for (int c = 1; c <= total; c++) begin
            if (c <= fw + 1)                        ph = 0;
            else if (c == fw + 2)                   ph = 1;
            else if (c == fw + 3)                   ph = 2;
            else if (has_mem && c <= fw + 4 + mw)   ph = 3;
            else                                    ph = 4;

            if (ph == 0)      rdy = (c == fw + 1);
            else if (ph == 3) rdy = (c == fw + 4 + mw);
            else              rdy = 1'($urandom_range(0, 1));
            mem_ready = rdy;

            @(negedge clk);
            // {mem_req, mem_we, addr_sel, ir_we, pc_we, reg_we, fault}
            expv = {(ph == 0 || ph == 3), (ph == 3 && st), (ph == 3),
                    (ph == 0 && rdy),
                    ((ph == 2 && br) || (ph == 3 && st && rdy) || ph == 4),
                    (ph == 4), 1'b0};
            obs  = {mem_req, mem_we, addr_sel, ir_we, pc_we, reg_we, fault};
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("FAIL strobes op=%b cycle=%0d: got %b, required %b",
                         op, c, obs, expv);
            end
            if (ph == 2 || ph == 3) begin
                if (ph == 2) begin
                    exp_imm = ld | st | (op == OPC_OPIMM);
                    exp_aop = (ld | st) ? 2'b00 : (br ? 2'b01 : 2'b10);
                end else begin
                    exp_imm = 1'b1;
                    exp_aop = 2'b00;
                end
                checks++;
                if (alu_src_imm !== exp_imm || alu_op !== exp_aop) begin
                    errors++;
                    $display("FAIL alu_ctrl op=%b cycle=%0d: got imm=%b op=%b, required imm=%b op=%b",
                             op, c, alu_src_imm, alu_op, exp_imm, exp_aop);
                end
            end
            if (ph == 4) begin
                checks++;
                if (mem_to_reg !== ld) begin
                    errors++;
                    $display("FAIL mem_to_reg op=%b: got %b, required %b", op, mem_to_reg, ld);
                end
            end
            @(posedge clk);
            #1;
        end
        $display("instr op=%b fw=%0d mw=%0d cycles=%0d done", op, fw, mw, total);
    endtask

    task automatic test_reset();
        reset        = 1'b1;
        opcode       = OPC_LOAD;
        mem_ready    = 1'b1;
        branch_taken = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({mem_req, mem_we, addr_sel, ir_we, pc_we, pc_src, alu_src_imm,
             alu_op, reg_we, mem_to_reg, fault} !== 12'b0 || retire_cnt !== 32'd0) begin
            errors++;
            $display("FAIL reset_outputs: got strobes nonzero or retire_cnt=%0d, required all 0", retire_cnt);
        end else begin
            $display("reset outputs all zero");
        end
        apply_reset();
    endtask

    task automatic test_opimm();
        run_instr(OPC_OPIMM, 1'b0, 0, 0);
    endtask

    task automatic test_load_wait();
        run_instr(OPC_LOAD, 1'b0, 0, 3);
    endtask

    task automatic test_branch();
        run_instr(OPC_BRANCH, 1'b1, 0, 0);
        run_instr(OPC_BRANCH, 1'b0, 0, 0);
    endtask

    task automatic test_store_illegal();
        run_instr(OPC_STORE, 1'b0, 0, 0);
        opcode    = OPC_ILLEGAL;
        mem_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (ir_we !== 1'b1 || mem_req !== 1'b1) begin
            errors++;
            $display("FAIL illegal_fetch: got ir_we=%b mem_req=%b, required 1 1", ir_we, mem_req);
        end
        @(posedge clk);
        #1;
        @(negedge clk);
        checks++;
        if ({mem_req, pc_we, reg_we, ir_we, fault} !== 5'b0) begin
            errors++;
            $display("FAIL illegal_decode: got strobes %b, required 00000",
                     {mem_req, pc_we, reg_we, ir_we, fault});
        end
        @(posedge clk);
        for (int i = 0; i < 20; i++) begin
            #1;
            mem_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            checks++;
            if (fault !== 1'b1 || mem_req !== 1'b0 || pc_we !== 1'b0 || reg_we !== 1'b0) begin
                errors++;
                $display("FAIL fault_hold cycle=%0d: got fault=%b mem_req=%b pc_we=%b reg_we=%b, required 1 0 0 0",
                         i, fault, mem_req, pc_we, reg_we);
            end
            @(posedge clk);
        end
        $display("illegal opcode held in fault for 20 cycles");
        #1;
        apply_reset();
        mem_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (fault !== 1'b0 || mem_req !== 1'b1) begin
            errors++;
            $display("FAIL fault_clear: got fault=%b mem_req=%b, required 0 1", fault, mem_req);
        end
        apply_reset();
    endtask

    task automatic test_timeout();
        opcode    = OPC_OPIMM;
        mem_ready = 1'b0;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            checks++;
            if (fault !== 1'b0 || mem_req !== 1'b1) begin
                errors++;
                $display("FAIL timeout_wait cycle=%0d: got fault=%b mem_req=%b, required 0 1",
                         c, fault, mem_req);
            end
            @(posedge clk);
        end
        #1;
        @(negedge clk);
        checks++;
        if (fault !== 1'b1 || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL timeout_fault: got fault=%b mem_req=%b, required 1 0", fault, mem_req);
        end else begin
            $display("timeout fault after 16 fetch cycles");
        end
        apply_reset();
        run_instr(OPC_OPIMM, 1'b0, 15, 0);
    endtask

    task automatic test_retire();
        logic [31:0] exp_cnt;
        apply_reset();
        for (int i = 0; i < 10; i++) run_instr(OPC_OP, 1'b0, 0, 0);
`ifdef RETIRE_CNT_EN
        exp_cnt = 32'd10;
`else
        exp_cnt = 32'd0;
`endif
        mem_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (retire_cnt !== exp_cnt) begin
            errors++;
            $display("FAIL retire_cnt: got %0d, required %0d", retire_cnt, exp_cnt);
        end else begin
            $display("retire_cnt=%0d after 10 OP", retire_cnt);
        end
    endtask

    task automatic test_reset_mid_mem();
        apply_reset();
        opcode    = OPC_LOAD;
        mem_ready = 1'b1;              // FETCH
        @(posedge clk); #1;
        mem_ready = 1'b0;              // DECODE
        @(posedge clk); #1;            // EXEC
        @(posedge clk); #1;            // MEM, stalled
        @(negedge clk);
        checks++;
        if (addr_sel !== 1'b1 || mem_req !== 1'b1 || mem_we !== 1'b0) begin
            errors++;
            $display("FAIL mid_mem: got addr_sel=%b mem_req=%b mem_we=%b, required 1 1 0",
                     addr_sel, mem_req, mem_we);
        end
        @(posedge clk); #1;
        reset     = 1'b1;
        mem_ready = 1'b1;
        @(negedge clk);
        checks++;
        if ({mem_req, pc_we, reg_we, fault} !== 4'b0 || retire_cnt !== 32'd0) begin
            errors++;
            $display("FAIL reset_mid_mem: got strobes %b retire_cnt=%0d, required 0000 0",
                     {mem_req, pc_we, reg_we, fault}, retire_cnt);
        end
        @(posedge clk); #1;
        reset     = 1'b0;
        mem_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (mem_req !== 1'b1 || addr_sel !== 1'b0 || retire_cnt !== 32'd0) begin
            errors++;
            $display("FAIL after_reset_fetch: got mem_req=%b addr_sel=%b retire_cnt=%0d, required 1 0 0",
                     mem_req, addr_sel, retire_cnt);
        end else begin
            $display("reset mid-MEM returned to FETCH");
        end
        apply_reset();
    endtask

    initial begin
        test_reset();
        test_opimm();
        test_load_wait();
        test_branch();
        test_store_illegal();
        test_timeout();
        test_retire();
        test_reset_mid_mem();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending retires, required 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Main control FSM for the multi-cycle RV64I core. It sequences fetch, decode, execute, memory and writeback over one shared memory port, using a req/ready handshake. It drives register-file, PC and IR write strobes and the ALU operand select that routes the immediate-generator output. It classifies the five supported opcodes and traps on anything else.

Parameters:
MEM_TIMEOUT, 16, max cycles waiting for mem_ready in FETCH/MEM before FAULT; 0 = no timeout
TO_W, 5, width of wait counter; must hold MEM_TIMEOUT

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-high reset
opcode  input  7  IR[6:0], valid from DECODE onward
branch_taken  input  1  ALU compare result, valid in EXEC
mem_ready  input  1  memory accepts/returns this cycle
mem_req  output  1  memory access request
mem_we  output  1  1 = write (store)
addr_sel  output  1  0 = PC, 1 = ALU result
ir_we  output  1  latch instruction register
pc_we  output  1  update PC (one pulse per retired instruction)
pc_src  output  1  0 = PC+4, 1 = branch target (PC+imm)
alu_src_imm  output  1  ALU operand B = imm_data (1) or rs2 (0)
alu_op  output  2  00 add, 01 sub/compare, 10 funct-decoded
reg_we  output  1  register-file write
mem_to_reg  output  1  writeback from memory data (1) or ALU (0)
fault  output  1  sticky illegal-opcode/timeout indicator
retire_cnt  output  32  retired-instruction count (see Optional Feature)

Behaviour:
- Opcode classes: LOAD 0000011, OPIMM 0010011, STORE 0100011, BRANCH 1100011, OP 0110011. Any other value is illegal.
- States: FETCH, DECODE, EXEC, MEM, WB, FAULT. The state register resets to FETCH.
- While reset is high, every output is 0. This includes combinational strobes, fault and retire_cnt.
- FETCH: mem_req=1, addr_sel=0, mem_we=0, ir_we=mem_ready. On mem_ready go to DECODE, otherwise stay.
- DECODE (1 cycle): legal opcode goes to EXEC; illegal goes to FAULT. No strobes.
- EXEC: alu_src_imm=1 for LOAD/OPIMM/STORE, 0 for OP/BRANCH. alu_op=00 for LOAD/STORE, 01 for BRANCH, 10 for OP/OPIMM.
  - BRANCH: pc_we=1, pc_src=branch_taken, then go to FETCH (retire).
  - LOAD/STORE: go to MEM.
  - OP/OPIMM: go to WB.
- MEM: mem_req=1, addr_sel=1, mem_we=(STORE), alu_src_imm=1, alu_op=00.
  - On mem_ready, LOAD goes to WB.
  - On mem_ready, STORE asserts pc_we=1, pc_src=0 and goes to FETCH (retire).
- WB: reg_we=1, mem_to_reg=(LOAD), pc_we=1, pc_src=0, then go to FETCH (retire).
- FAULT: fault=1 and all other strobes 0. The FSM stays in FAULT until reset.
- Opcode is sampled combinationally every cycle. IR is stable from DECODE until the next FETCH.
- Latency with zero-wait memory:
  - BRANCH: 3 cycles
  - OP, OPIMM, STORE: 4 cycles
  - LOAD: 5 cycles
- Each mem_ready-low cycle in FETCH/MEM adds one cycle.
- Wait counter:
  - Increments each FETCH/MEM cycle with mem_ready=0.
  - Clears on any state change.
  - If MEM_TIMEOUT>0, the counter equals MEM_TIMEOUT-1 and mem_ready=0, the next state is FAULT.
  - If mem_ready arrives on that same cycle, ready wins and the access completes.
- mem_ready outside FETCH/MEM is ignored.
- Reset mid-access: the FSM returns to FETCH next cycle and the wait counter clears. No pc_we/reg_we pulse is emitted.

Optional Feature:
RETIRE_CNT_EN
- Defined: retire_cnt increments by 1 on every cycle where pc_we=1. It wraps from 0xFFFFFFFF to 0, clears on reset, and freezes in FAULT.
- Undefined: retire_cnt is tied to 0 and no counter register is built. The port remains.

Test Plan:
- OPIMM (0010011), mem_ready held 1: FETCH→DECODE→EXEC→WB. ir_we in cycle 1; alu_src_imm=1 and alu_op=10 in EXEC; reg_we=1 and pc_we=1 in cycle 4 only; back to FETCH in cycle 5.
- LOAD with mem_ready low for 3 cycles in MEM: LOAD takes 8 cycles total. addr_sel=1 and mem_we=0 throughout MEM; WB asserts mem_to_reg=1 and reg_we=1.
- BRANCH, branch_taken=1 then a second BRANCH with branch_taken=0: each takes 3 cycles. pc_src=1 then 0 on the EXEC pc_we pulse; reg_we never asserts.
- STORE, then illegal opcode 1111111: STORE pulses mem_we=1 and pc_we on the ready cycle. The illegal opcode enters FAULT after DECODE; fault stays 1 and mem_req stays 0 for 20 cycles; reset clears fault.
- MEM_TIMEOUT=16, mem_ready held 0 in FETCH: FAULT is entered after exactly 16 FETCH cycles. A repeat run with mem_ready=1 on cycle 16 completes the fetch with no fault.
- RETIRE_CNT_EN defined: 10 OP instructions give retire_cnt=10. Reset asserted mid-MEM gives retire_cnt=0 and FETCH next cycle. Undefined: retire_cnt stays 0.
